// File: rtl/line_decoder_seq.sv
// Registered SEL_W-to-2**SEL_W line decoder with one-hot/thermometer output
// and an auto-advancing index for sequential line scans.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no index loaded since reset; D inactive, step ignored
// ST_ACTIVE | index loaded; D follows idx/mode while en=1, step may advance
module line_decoder_seq #(
    parameter int SEL_W      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [SEL_W-1:0]        A,
    input  logic [1:0]              mode,
    input  logic                    step,
    input  logic                    en,
    output logic [(2**SEL_W)-1:0]   D,
    output logic [SEL_W-1:0]        idx,
    output logic                    valid,
    output logic                    wrap
);

    localparam int                  OUT_W      = 2**SEL_W;
    localparam logic [SEL_W-1:0]    IDX_MAX    = '1;
    localparam logic [OUT_W-1:0]    D_INACTIVE = {OUT_W{ACTIVE_LOW}};
    localparam logic [OUT_W-1:0]    D_LSB      = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_idx;
    logic [1:0]         r_mode;
    logic               r_wrap;
    logic [OUT_W-1:0]   r_d;

    state_t             w_state_next;
    logic [SEL_W-1:0]   w_idx_next;
    logic [1:0]         w_mode_next;
    logic               w_wrap_next;
    logic [OUT_W-1:0]   w_onehot;
    logic [OUT_W-1:0]   w_therm;
    logic [OUT_W-1:0]   w_d_active;
    logic [OUT_W-1:0]   w_d_next;

    // load has priority over step; a step only counts once a scan is armed
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_mode_next  = r_mode;
        w_wrap_next  = 1'b0;
        if (load) begin
            w_state_next = ST_ACTIVE;
            w_idx_next   = A;
            w_mode_next  = mode;
        end else if ((r_state == ST_ACTIVE) && r_mode[1] && step) begin
            w_idx_next  = r_idx + 1'b1;
            w_wrap_next = (r_idx == IDX_MAX);
        end
    end

    // Thermometer = all bits at or below idx: (onehot << 1) - 1, which
    // naturally becomes all-ones when idx is the top line.
    always_comb begin
        w_onehot   = D_LSB << w_idx_next;
        w_therm    = (w_onehot << 1) - D_LSB;
        w_d_active = '0;
        if ((w_state_next == ST_ACTIVE) && en) begin
            w_d_active = w_mode_next[0] ? w_therm : w_onehot;
        end
        w_d_next = ACTIVE_LOW ? ~w_d_active : w_d_active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mode  <= 2'b00;
            r_wrap  <= 1'b0;
            r_d     <= D_INACTIVE;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_mode  <= w_mode_next;
            r_wrap  <= w_wrap_next;
            r_d     <= w_d_next;
        end
    end

    assign D     = r_d;
    assign idx   = r_idx;
    assign valid = (r_state == ST_ACTIVE);
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_line_decoder_seq.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares;
// an active-high and an active-low instance share the same stimulus.
module tb_line_decoder_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  A = 4'd0;
    logic [1:0]  mode = 2'b00;
    logic        step = 1'b0;
    logic        en = 1'b0;

    logic [15:0] d0, d1;
    logic [3:0]  idx0, idx1;
    logic        valid0, valid1, wrap0, wrap1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  idx;
        logic        valid;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int         m_idx;
    logic [1:0] m_mode;
    logic       m_valid;
    logic       m_wrap;
    logic [15:0] m_d;

    always #5 clk = ~clk;

    line_decoder_seq #(.SEL_W(4), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .load(load), .A(A), .mode(mode),
        .step(step), .en(en), .D(d0), .idx(idx0), .valid(valid0), .wrap(wrap0)
    );

    line_decoder_seq #(.SEL_W(4), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .load(load), .A(A), .mode(mode),
        .step(step), .en(en), .D(d1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.d     = m_d;
        e.idx   = m_idx[3:0];
        e.valid = m_valid;
        e.wrap  = m_wrap;
        return e;
    endfunction

    function automatic void model_reset();
        m_idx   = 0;
        m_mode  = 2'b00;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_d     = 16'h0000;
    endfunction

    // Spec rules applied directly: lines active at or (thermometer) below idx.
    function automatic void model_edge(input logic l, input logic [3:0] a,
                                       input logic [1:0] md, input logic s, input logic e);
        if (l) begin
            m_idx   = int'(a);
            m_mode  = md;
            m_valid = 1'b1;
            m_wrap  = 1'b0;
        end else if (m_valid && m_mode[1] && s) begin
            m_wrap = (m_idx == 15);
            m_idx  = (m_idx + 1) % 16;
        end else begin
            m_wrap = 1'b0;
        end
        m_d = 16'h0000;
        if (m_valid && e) begin
            for (int i = 0; i < 16; i++) begin
                m_d[i] = m_mode[0] ? (i <= m_idx) : (i == m_idx);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("d_hi",  {16'h0, d0},     {16'h0, mon_e.d});
            chk("d_lo",  {16'h0, d1},     {16'h0, ~mon_e.d});
            chk("idx",   {28'h0, idx0},   {28'h0, mon_e.idx});
            chk("idx_lo",{28'h0, idx1},   {28'h0, mon_e.idx});
            chk("valid", {31'h0, valid0}, {31'h0, mon_e.valid});
            chk("wrap",  {31'h0, wrap0},  {31'h0, mon_e.wrap});
            chk("lo_ctl",{30'h0, valid1, wrap1}, {30'h0, mon_e.valid, mon_e.wrap});
        end
    end

    // Called positioned just after a falling edge.
    task automatic cycle(input logic l, input logic [3:0] a, input logic [1:0] md,
                         input logic s, input logic e);
        load = l; A = a; mode = md; step = s; en = e;
        @(posedge clk);
        model_edge(l, a, md, s, e);
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_d_hi",  {16'h0, d0}, 32'h0000);
        chk("rst_d_lo",  {16'h0, d1}, 32'hFFFF);
        chk("rst_valid", {30'h0, valid0, valid1}, 32'h0);
        chk("rst_idx",   {24'h0, idx0, idx1}, 32'h0);
        chk("rst_wrap",  {30'h0, wrap0, wrap1}, 32'h0);
        model_reset();
        exp_q.push_back(snapshot());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        exp_q.push_back(snapshot());
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 4'd5,  2'b00, 1'b0, 1'b1);
        cycle(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);
        cycle(1'b1, 4'd3,  2'b01, 1'b0, 1'b1);
        cycle(1'b1, 4'd15, 2'b01, 1'b0, 1'b1);
        cycle(1'b1, 4'd14, 2'b10, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 4'd0, 2'b00, 1'b1, 1'b1);
        cycle(1'b1, 4'd9,  2'b10, 1'b0, 1'b1);
        cycle(1'b1, 4'd2,  2'b10, 1'b1, 1'b1);
        cycle(1'b1, 4'd7,  2'b00, 1'b0, 1'b1);
        cycle(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);
        cycle(1'b1, 4'd12, 2'b11, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 4'd0,  2'b00, 1'b0, 1'b1);
        async_reset();
        cycle(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);
        cycle(1'b1, 4'd0,  2'b00, 1'b0, 1'b1);
        cycle(1'b1, 4'd13, 2'b10, 1'b0, 1'b1);
        cycle(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);
        async_reset();
        cycle(1'b0, 4'd0,  2'b00, 1'b1, 1'b1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(7) == 0, 4'($urandom_range(15)),
                      2'($urandom_range(3)), $urandom_range(3) != 0,
                      $urandom_range(7) != 0);
            end
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
